// File: rtl/nibble_sched_pkg.sv
// nibble_sched_pkg: shared widths and result-slot state encoding for the nibble adder scheduler
package nibble_sched_pkg;
  localparam int NIBBLE_W = 4;
  localparam int SUM_W = 5;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/nibble_add_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr; ptr moves past the winner on advance
module rr_arbiter #(
  parameter int N = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx
);
  logic [ID_W-1:0] r_ptr;
  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(r_ptr) + k) % N]) begin
        grant = N'(1) << ((int'(r_ptr) + k) % N);
        grant_idx = ID_W'((int'(r_ptr) + k) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (advance) r_ptr <= (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/nibble_add_scheduler.sv
// nibble_add_scheduler: shares one nibble adder among NUM_REQ requesters with a single registered result slot
module nibble_add_scheduler
  import nibble_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 16,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NIBBLE_W*NUM_REQ-1:0]  req_a,
  input  logic [NIBBLE_W*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [SUM_W-1:0]             rsp_sum,
  output logic [ID_W-1:0]              rsp_id,
  output logic [CNT_W-1:0]             ops_count
);
  slot_state_t       r_state, w_state_nxt;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_can_accept, w_accept, w_consume;
  logic [SUM_W-1:0]  r_sum;
  logic [ID_W-1:0]   r_id;
  logic [CNT_W-1:0]  r_cnt;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (w_accept),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  assign w_can_accept = ena && !rst && (r_state == SLOT_EMPTY || rsp_ready);
  assign req_ready = w_can_accept ? w_grant : '0;
  assign w_accept = |req_ready;
  assign w_consume = (r_state == SLOT_FULL) && rsp_ready;

  always_comb w_state_nxt = w_accept ? SLOT_FULL : w_consume ? SLOT_EMPTY : r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_sum <= '0;
      r_id <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sum <= {1'b0, req_a[w_idx*NIBBLE_W +: NIBBLE_W]} + {1'b0, req_b[w_idx*NIBBLE_W +: NIBBLE_W]};
        r_id <= w_idx;
      end
      if (w_consume && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rsp_valid = (r_state == SLOT_FULL);
  assign rsp_sum = r_sum;
  assign rsp_id = r_id;
  assign ops_count = r_cnt;
endmodule

// File: tb/tb_nibble_add_scheduler.sv
// tb_nibble_add_scheduler: directed vectors with a result scoreboard popped on every output handshake
module tb_nibble_add_scheduler;
  logic        clk = 0, rst = 1, ena = 1, rsp_ready = 1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0]  req_ready, req_ready_s;
  logic        rsp_valid, rsp_valid_s;
  logic [4:0]  rsp_sum, rsp_sum_s;
  logic [1:0]  rsp_id, rsp_id_s;
  logic [15:0] ops_count;
  logic [1:0]  ops_count_s;
  logic [6:0]  sb[$];
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  nibble_add_scheduler u_dut (
    .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .ops_count(ops_count)
  );

  nibble_add_scheduler #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum_s),
    .rsp_id(rsp_id_s), .ops_count(ops_count_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        logic [6:0] e;
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e[6:5]);
        chk("rsp_sum", rsp_sum, e[4:0]);
      end
    end
  end

  task automatic step(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                      input logic rr, input logic en, input logic [3:0] exp_rdy, input logic exp_rv);
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr; ena = en;
    @(negedge clk);
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_rv);
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) sb.push_back({2'(i), 5'({1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]})});
    @(posedge clk); #1;
  endtask

  initial begin
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("req_ready_in_reset", req_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    chk("reset_valid", rsp_valid, 0);
    chk("reset_sum", rsp_sum, 0);
    chk("reset_id", rsp_id, 0);
    chk("reset_count", ops_count, 0);
    // fairness: all valid, ids 0,1,2,3,0,1 with no bubbles
    step(4'hF, 16'h4321, 16'h8642, 1, 1, 4'b0001, 0);
    step(4'hF, 16'h4321, 16'h8642, 1, 1, 4'b0010, 1);
    step(4'hF, 16'h4321, 16'h8642, 1, 1, 4'b0100, 1);
    step(4'hF, 16'h4321, 16'h8642, 1, 1, 4'b1000, 1);
    step(4'hF, 16'h4321, 16'h8642, 1, 1, 4'b0001, 1);
    step(4'hF, 16'h4321, 16'h8642, 1, 1, 4'b0010, 1);
    // single request and 5-bit sums
    step(4'b0001, 16'h0003, 16'h0004, 1, 1, 4'b0001, 1);
    chk("t1_sum", rsp_sum, 7);
    step(4'b0001, 16'h000F, 16'h000F, 1, 1, 4'b0001, 1);
    chk("t2_sum30", rsp_sum, 30);
    step(4'b0001, 16'h0000, 16'h0000, 1, 1, 4'b0001, 1);
    step(4'b0000, 16'h0000, 16'h0000, 1, 1, 4'b0000, 1);
    step(4'b0000, 16'h0000, 16'h0000, 1, 1, 4'b0000, 0);
    // backpressure with held result sum=9 id=2
    step(4'b0100, 16'h0400, 16'h0500, 1, 1, 4'b0100, 0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 16'h0021, 16'h0011, 0, 1, 4'b0000, 1);
      chk("stall_sum", rsp_sum, 9);
      chk("stall_id", rsp_id, 2);
    end
    step(4'b0011, 16'h0021, 16'h0011, 1, 1, 4'b0001, 1);
    chk("ops_before_ena", ops_count, 10);
    // ena low drains held result without accepting
    step(4'b0010, 16'h0050, 16'h0060, 1, 0, 4'b0000, 1);
    chk("ops_after_drain", ops_count, 11);
    step(4'b0010, 16'h0050, 16'h0060, 1, 0, 4'b0000, 0);
    step(4'b0010, 16'h0050, 16'h0060, 1, 1, 4'b0010, 0);
    step(4'b0000, 16'h0000, 16'h0000, 1, 1, 4'b0000, 1);
    // reset mid-operation discards the held result
    step(4'b0100, 16'h0700, 16'h0100, 1, 1, 4'b0100, 0);
    rst = 1; rsp_ready = 0; req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    sb.delete();
    rst = 0;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_count", ops_count, 0);
    step(4'b1001, 16'h2002, 16'h1003, 1, 1, 4'b0001, 0);
    for (int i = 0; i < 4; i++) step(4'b0001, 16'h0006, 16'h0007, 1, 1, 4'b0001, 1);
    step(4'b0000, 16'h0000, 16'h0000, 1, 1, 4'b0000, 1);
    chk("ops_five", ops_count, 5);
    chk("ops_saturated", ops_count_s, 3);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
